// File: rtl/reset_input_conditioner.sv
// Synchronises, debounces and qualifies raw reset sources into one registered reset request.
// Latency to assert: debug SYNC_STAGES+1, aux SYNC_STAGES+DEBOUNCE_CYCLES+1, lock loss SYNC_STAGES+2 edges.
module reset_input_conditioner #(
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int MIN_PULSE_CYCLES   = 16
) (
  input  logic       slowest_sync_clk,
  input  logic       ext_reset_in,
  input  logic       aux_reset_in,
  input  logic       mb_debug_sys_rst,
  input  logic       dcm_locked,
  input  logic       cause_clr,
  output logic       sys_reset_req,
  output logic       lock_qualified,
  output logic       aux_reset_filt,
  output logic [2:0] reset_cause,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int SW = $clog2(MIN_PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } fsm_t;

  logic [SYNC_STAGES-1:0] aux_sync;
  logic [SYNC_STAGES-1:0] dbg_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   aux_s;
  logic                   dbg_s;
  logic                   lock_s;

  logic [DW-1:0]          deb_cnt;
  logic [LW-1:0]          lock_cnt;
  logic [SW-1:0]          stretch_cnt;

  logic                   src;
  logic                   cause_set;
  logic [2:0]             cause_bits;

  fsm_t                   state_q;
  fsm_t                   state_d;

  // Aux synchroniser idles high so the block powers up in reset.
  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      aux_sync  <= '1;
      dbg_sync  <= '0;
      lock_sync <= '0;
    end else begin
      aux_sync  <= {aux_sync[SYNC_STAGES-2:0], aux_reset_in};
      dbg_sync  <= {dbg_sync[SYNC_STAGES-2:0], mb_debug_sys_rst};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], dcm_locked};
    end
  end

  assign aux_s  = aux_sync[SYNC_STAGES-1];
  assign dbg_s  = dbg_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Filtered level only moves after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      deb_cnt        <= '0;
      aux_reset_filt <= 1'b1;
    end else if (aux_s != aux_reset_filt) begin
      if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        aux_reset_filt <= aux_s;
        deb_cnt        <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Counter saturates one below the target; qualification follows on the next edge.
  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      lock_cnt       <= '0;
      lock_qualified <= 1'b0;
    end else if (!lock_s) begin
      lock_cnt       <= '0;
      lock_qualified <= 1'b0;
    end else begin
      if (lock_cnt != LW'(LOCK_STABLE_CYCLES - 1)) begin
        lock_cnt <= lock_cnt + LW'(1);
      end
      lock_qualified <= (lock_cnt == LW'(LOCK_STABLE_CYCLES - 1));
    end
  end

  assign src = aux_reset_filt | dbg_s | ~lock_qualified;

  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD: begin
        if (!src) begin
          state_d = STRETCH;
        end
      end
      STRETCH: begin
        if (src) begin
          state_d = HOLD;
        end else if (stretch_cnt == SW'(MIN_PULSE_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (src) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    sys_reset_req = (state_q != RUN);
    state         = state_q;
  end

  // Counts only while the stretch continues undisturbed; any other path restarts from zero.
  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      stretch_cnt <= '0;
    end else if ((state_q == STRETCH) && (state_d == STRETCH)) begin
      stretch_cnt <= stretch_cnt + SW'(1);
    end else begin
      stretch_cnt <= '0;
    end
  end

  assign cause_set  = (state_q == RUN) && src;
  assign cause_bits = {~lock_qualified, dbg_s, aux_reset_filt};

  // A new run-time reset overrides a coincident clear.
  always_ff @(posedge slowest_sync_clk or negedge ext_reset_in) begin
    if (!ext_reset_in) begin
      reset_cause <= 3'b000;
    end else if (cause_set && cause_clr) begin
      reset_cause <= cause_bits;
    end else if (cause_set) begin
      reset_cause <= reset_cause | cause_bits;
    end else if (cause_clr) begin
      reset_cause <= 3'b000;
    end
  end

endmodule

// File: tb/tb_reset_input_conditioner.sv
// Directed bench for reset_input_conditioner: a table of timed phases plus hand-written corner sequences.
module tb_reset_input_conditioner;

  logic       slowest_sync_clk = 1'b0;
  logic       ext_reset_in;
  logic       aux_reset_in;
  logic       mb_debug_sys_rst;
  logic       dcm_locked;
  logic       cause_clr;
  logic       sys_reset_req;
  logic       lock_qualified;
  logic       aux_reset_filt;
  logic [2:0] reset_cause;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         adv;
    logic       aux;
    logic       dbg;
    logic       lock;
    logic       clr;
    logic       req;
    logic [1:0] st;
    logic       lq;
    logic       filt;
    logic [2:0] cause;
  } vec_t;

  vec_t vq[$];

  always #5 slowest_sync_clk = ~slowest_sync_clk;

  reset_input_conditioner dut (
    .slowest_sync_clk (slowest_sync_clk),
    .ext_reset_in     (ext_reset_in),
    .aux_reset_in     (aux_reset_in),
    .mb_debug_sys_rst (mb_debug_sys_rst),
    .dcm_locked       (dcm_locked),
    .cause_clr        (cause_clr),
    .sys_reset_req    (sys_reset_req),
    .lock_qualified   (lock_qualified),
    .aux_reset_filt   (aux_reset_filt),
    .reset_cause      (reset_cause),
    .state            (state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge slowest_sync_clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // {req, state, lock_qualified, aux_reset_filt, reset_cause}
  function automatic logic [7:0] snap();
    return {sys_reset_req, state, lock_qualified, aux_reset_filt, reset_cause};
  endfunction

  task automatic add(input int adv, input int a, input int d, input int l, input int c,
                     input int r, input int s, input int q, input int f, input int ca);
    vec_t v;
    v.adv   = adv;
    v.aux   = a[0];
    v.dbg   = d[0];
    v.lock  = l[0];
    v.clr   = c[0];
    v.req   = r[0];
    v.st    = s[1:0];
    v.lq    = q[0];
    v.filt  = f[0];
    v.cause = ca[2:0];
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] exp_v;

    // Power-up: lock qualifies at edge 66, stretch edges 67..82, RUN at 83.
    add(17, 0,0,1,0, 1,0,0,1,0);
    add( 1, 0,0,1,0, 1,0,0,0,0);
    add(47, 0,0,1,0, 1,0,0,0,0);
    add( 1, 0,0,1,0, 1,0,1,0,0);
    add( 1, 0,0,1,0, 1,1,1,0,0);
    add(15, 0,0,1,0, 1,1,1,0,0);
    add( 1, 0,0,1,0, 0,2,1,0,0);
    add(10, 0,0,1,0, 0,2,1,0,0);
    // Three-cycle debug pulse: HOLD at edge 3, RUN again at edge 22.
    add( 2, 0,1,1,0, 0,2,1,0,0);
    add( 1, 0,1,1,0, 1,0,1,0,2);
    add( 2, 0,0,1,0, 1,0,1,0,2);
    add( 1, 0,0,1,0, 1,1,1,0,2);
    add(15, 0,0,1,0, 1,1,1,0,2);
    add( 1, 0,0,1,0, 0,2,1,0,2);
    // Ten-cycle aux glitch is swallowed.
    add(10, 1,0,1,0, 0,2,1,0,2);
    add(20, 0,0,1,0, 0,2,1,0,2);
    // Twenty-cycle aux pulse: filt at edge 18, HOLD at 19, filt clears at 38, RUN at 55.
    add(17, 1,0,1,0, 0,2,1,0,2);
    add( 1, 1,0,1,0, 0,2,1,1,2);
    add( 1, 1,0,1,0, 1,0,1,1,3);
    add( 1, 1,0,1,0, 1,0,1,1,3);
    add(17, 0,0,1,0, 1,0,1,1,3);
    add( 1, 0,0,1,0, 1,0,1,0,3);
    add( 1, 0,0,1,0, 1,1,1,0,3);
    add(15, 0,0,1,0, 1,1,1,0,3);
    add( 1, 0,0,1,0, 0,2,1,0,3);
    // Standalone clear, then a one-cycle lock drop.
    add( 1, 0,0,1,1, 0,2,1,0,0);
    add( 1, 0,0,0,0, 0,2,1,0,0);
    add( 2, 0,0,1,0, 0,2,0,0,0);
    add( 1, 0,0,1,0, 1,0,0,0,4);
    add(62, 0,0,1,0, 1,0,0,0,4);
    add( 1, 0,0,1,0, 1,0,1,0,4);
    add( 1, 0,0,1,0, 1,1,1,0,4);
    add(15, 0,0,1,0, 1,1,1,0,4);
    add( 1, 0,0,1,0, 0,2,1,0,4);

    ext_reset_in     = 1'b0;
    aux_reset_in     = 1'b0;
    mb_debug_sys_rst = 1'b0;
    dcm_locked       = 1'b1;
    cause_clr        = 1'b0;
    tick(3);
    chk("reset_state", snap(), 8'b1_00_0_1_000);
    ext_reset_in = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      aux_reset_in     = vq[i].aux;
      mb_debug_sys_rst = vq[i].dbg;
      dcm_locked       = vq[i].lock;
      cause_clr        = vq[i].clr;
      tick(vq[i].adv);
      exp_v = {vq[i].req, vq[i].st, vq[i].lq, vq[i].filt, vq[i].cause};
      chk($sformatf("vec%0d", i), snap(), exp_v);
    end
    aux_reset_in     = 1'b0;
    mb_debug_sys_rst = 1'b0;
    dcm_locked       = 1'b1;
    cause_clr        = 1'b0;

    // Stretch interrupted at count 8 by a second debug pulse, then a full restart.
    mb_debug_sys_rst = 1'b1;
    tick(1);
    mb_debug_sys_rst = 1'b0;
    tick(2);
    chk("stint_hold", state, 8'd0);
    tick(1);
    chk("stint_stretch", state, 8'd1);
    tick(6);
    mb_debug_sys_rst = 1'b1;
    tick(1);
    mb_debug_sys_rst = 1'b0;
    tick(1);
    chk("stint_cnt8", state, 8'd1);
    tick(1);
    chk("stint_abort", {sys_reset_req, state}, 8'b100);
    tick(1);
    chk("stint_restart", state, 8'd1);
    tick(15);
    chk("stint_full16", {sys_reset_req, state}, 8'b101);
    tick(1);
    chk("stint_run", {sys_reset_req, state}, 8'b010);
    chk("stint_cause", reset_cause, 8'd6);

    // Clear on the same edge as a debug-caused RUN to HOLD: new cause replaces old.
    mb_debug_sys_rst = 1'b1;
    tick(1);
    mb_debug_sys_rst = 1'b0;
    tick(1);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    chk("clr_set_wins", {state, reset_cause}, 8'b00_010);
    tick(17);
    chk("clr_back_run", state, 8'd2);

    // Asynchronous reset in the middle of a stretch.
    mb_debug_sys_rst = 1'b1;
    tick(1);
    mb_debug_sys_rst = 1'b0;
    tick(7);
    chk("midrst_pre", state, 8'd1);
    #2;
    ext_reset_in = 1'b0;
    #1;
    chk("midrst_async", snap(), 8'b1_00_0_1_000);
    tick(2);
    ext_reset_in = 1'b1;
    tick(82);
    chk("midrst_relock", {sys_reset_req, state}, 8'b101);
    tick(1);
    chk("midrst_run", snap(), 8'b0_10_1_0_000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_input_conditioner.md
Name: reset_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the processor system reset block.
- Synchronises, debounces and qualifies the raw reset sources: aux reset, debug system reset and DCM/MMCM lock.
- Enforces a minimum reset pulse width.
- Drives a single clean, registered reset request that the downstream reset block consumes as its combined reset condition.
- Also records a sticky cause of the most recent run-time reset.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for asynchronous inputs; legal values 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the filtered aux level changes; must be at least 2.
- LOCK_STABLE_CYCLES, 64: consecutive cycles with lock high required before lock is qualified; must be at least 2.
- MIN_PULSE_CYCLES, 16: minimum number of cycles sys_reset_req stays high after all sources clear; must be at least 1.

Ports:
- slowest_sync_clk, input, 1: single clock for the whole block.
- ext_reset_in, input, 1: asynchronous, active-low block reset.
- aux_reset_in, input, 1: raw auxiliary reset, active-high, asynchronous.
- mb_debug_sys_rst, input, 1: debug system reset, active-high, asynchronous.
- dcm_locked, input, 1: clock generator lock, asynchronous.
- cause_clr, input, 1: synchronous pulse that clears reset_cause.
- sys_reset_req, output, 1: conditioned reset request, active-high, registered.
- lock_qualified, output, 1: lock has been stable for LOCK_STABLE_CYCLES.
- aux_reset_filt, output, 1: debounced aux reset level.
- reset_cause, output, 3: sticky cause; bit0 = aux, bit1 = debug, bit2 = lock loss.
- state, output, 2: FSM state; HOLD = 0, STRETCH = 1, RUN = 2.

Behaviour:
- Reset (ext_reset_in = 0, asynchronous) forces:
  - state = HOLD, sys_reset_req = 1, lock_qualified = 0, aux_reset_filt = 1, reset_cause = 0;
  - all counters = 0;
  - aux synchroniser flops = 1; debug and lock synchroniser flops = 0.
- Reset is held for as long as ext_reset_in = 0. Reset asserted mid-operation aborts everything immediately; no state survives.
- Synchronisers: aux, debug and lock each pass through SYNC_STAGES flops, producing aux_s, dbg_s and lock_s.
- Aux debounce:
  - If aux_s differs from aux_reset_filt, the debounce counter increments; otherwise it clears to 0.
  - After DEBOUNCE_CYCLES consecutive differing cycles, aux_reset_filt takes the value of aux_s and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the output.
- Debug path: dbg_s is used undebounced. A single synchronised cycle high is a valid request.
- Lock qualification:
  - While lock_s = 1, the lock counter increments and saturates.
  - lock_qualified rises on the edge after LOCK_STABLE_CYCLES consecutive lock_s = 1 cycles.
  - Any cycle with lock_s = 0 clears the counter and lock_qualified at the next edge.
- Combined source: src = aux_reset_filt OR dbg_s OR NOT lock_qualified.
- FSM (registered; sys_reset_req = 1 in HOLD and STRETCH, 0 in RUN, decoded from the state register):
  - HOLD: if src = 0, go to STRETCH with the stretch counter = 0; otherwise stay in HOLD.
  - STRETCH: if src = 1, go to HOLD and clear the counter. Otherwise the counter increments. When it reaches MIN_PULSE_CYCLES-1 with src = 0, go to RUN. STRETCH therefore lasts exactly MIN_PULSE_CYCLES cycles when undisturbed.
  - RUN: if src = 1, go to HOLD, so sys_reset_req rises one edge after src rises. Otherwise stay in RUN.
- Latency, raw input to sys_reset_req assert:
  - debug: SYNC_STAGES+1 edges;
  - aux: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges;
  - lock loss: SYNC_STAGES+2 edges.
- reset_cause:
  - On a RUN to HOLD transition, the bits of the sources active in that cycle are OR-ed in.
  - Sources in HOLD or STRETCH do not set bits, so power-up lock acquisition records nothing.
  - cause_clr clears all bits. If set and clear occur in the same cycle, set wins.
- Simultaneous sources: all active causes are recorded together. The FSM treats them as a single src.

Test Plan:
- Power-up: ext_reset_in 0→1 with dcm_locked = 1, aux = 0, debug = 0 (constant) -> sys_reset_req stays 1, then falls between 80 and 84 cycles after release; state ends at 2; reset_cause = 0.
- Debug pulse: in RUN, a 3-cycle mb_debug_sys_rst pulse -> sys_reset_req rises 3 edges after the pulse starts. It stays high for at least 16 cycles after dbg_s clears, then returns to 0. reset_cause = 3'b010.
- Aux glitch filtering, in RUN:
  - a 10-cycle aux pulse -> sys_reset_req never asserts;
  - a 20-cycle aux pulse -> sys_reset_req asserts 19 edges after the pulse starts; reset_cause bit0 = 1.
- Lock loss: in RUN, drop dcm_locked for 1 cycle -> lock_qualified falls and sys_reset_req rises. Re-qualification takes 64 cycles, then 16 stretch cycles before RUN. reset_cause = 3'b100.
- Stretch interrupt: a debug pulse arriving in STRETCH cycle 8 -> state returns to 0. After the source clears, a full 16-cycle stretch restarts.
- Mid-operation reset and cause clear:
  - ext_reset_in low while in STRETCH -> all outputs return to their reset values asynchronously.
  - cause_clr pulsed on the same edge as a RUN→HOLD transition caused by debug -> reset_cause = 3'b010 (set wins).
